// File: rtl/split_pipe_pkg.sv
// split_pipe_pkg: shared widths, field offsets, FSM encoding and defaults for the split_pipe bus splitter.
package split_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    // Request is {valid, addr, wdata, wstrb}; response is {rdata, ready}.
    localparam int unsigned WSTRB_LSB = 0;
    localparam int unsigned READY_BIT = 0;
    localparam int unsigned RDATA_LSB = 1;

    function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int unsigned resp_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned valid_bit(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int unsigned wdata_lsb(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/split_pipe_timer.sv
// split_pipe_timer: loadable up-counter with enable, clear and a terminal-count flag.
module split_pipe_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == term);

endmodule

// File: rtl/split_pipe.sv
// split_pipe: 1-to-N native-bus split with one outstanding transaction and error responses.
// Define SPLIT_PIPE_REG_EN to register both the slave request and the master response paths.
module split_pipe
    import split_pipe_pkg::*;
#(
    parameter int unsigned       N_SLAVES = 3,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       P_SLAVES = 31,
    parameter int unsigned       TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [req_w(ADDR_W, DATA_W)-1:0]          m_req,
    output logic [resp_w(DATA_W)-1:0]                 m_resp,
    output logic [N_SLAVES*req_w(ADDR_W, DATA_W)-1:0] s_req,
    input  logic [N_SLAVES*resp_w(DATA_W)-1:0]        s_resp,
    output logic                                      err,
    output logic [ADDR_W-1:0]                         err_addr
);

    localparam int unsigned      REQ_W     = req_w(ADDR_W, DATA_W);
    localparam int unsigned      RESP_W    = resp_w(DATA_W);
    localparam int unsigned      STRB_W    = DATA_W / 8;
    localparam int unsigned      VALID_BIT = valid_bit(ADDR_W, DATA_W);
    localparam int unsigned      ADDR_LSB  = addr_lsb(DATA_W);
    localparam int unsigned      WDATA_LSB = wdata_lsb(DATA_W);
    localparam int unsigned      SEL_W     = sel_w(N_SLAVES);
    localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SEL_W:0]   N_SEL     = (SEL_W + 1)'(N_SLAVES);
    localparam logic [CNT_W-1:0] TERM      = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t                             state, state_nx;
    logic                               m_valid;
    logic [ADDR_W-1:0]                  m_addr;
    logic [SEL_W-1:0]                   sel_c, sel_q;
    logic                               mapped_c;
    logic                               fwd_valid;
    logic [SEL_W-1:0]                   fwd_sel;
    logic [VALID_BIT-1:0]               fwd_payload;
    logic [N_SLAVES-1:0]                s_ready;
    logic [N_SLAVES-1:0][DATA_W-1:0]    s_rdata;
    logic                               hit_ready_c;
    logic [DATA_W-1:0]                  hit_rdata_c;
    logic                               tc_c, timeout_c, resp_hold_c, err_evt_c;
    logic [RESP_W-1:0]                  resp_c;

    assign m_valid  = m_req[VALID_BIT];
    assign m_addr   = m_req[ADDR_LSB +: ADDR_W];
    assign sel_c    = m_addr[P_SLAVES -: SEL_W];
    assign mapped_c = ({1'b0, sel_c} < N_SEL);

    // Payload is broadcast; only the routed slave sees valid.
    for (genvar k = 0; k < N_SLAVES; k++) begin : g_slv
        assign s_req[k*REQ_W + VALID_BIT]              = fwd_valid && (fwd_sel == SEL_W'(k));
        assign s_req[k*REQ_W + ADDR_LSB +: ADDR_W]     = fwd_payload[ADDR_LSB +: ADDR_W];
        assign s_req[k*REQ_W + WDATA_LSB +: DATA_W]    = fwd_payload[WDATA_LSB +: DATA_W];
        assign s_req[k*REQ_W + WSTRB_LSB +: STRB_W]    = fwd_payload[WSTRB_LSB +: STRB_W];
        assign s_ready[k] = s_resp[k*RESP_W + READY_BIT];
        assign s_rdata[k] = s_resp[k*RESP_W + RDATA_LSB +: DATA_W];
    end

    // Ready from a slave whose valid is low never reaches the master.
    always_comb begin
        hit_ready_c = 1'b0;
        hit_rdata_c = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (fwd_sel == SEL_W'(k)) begin
                hit_ready_c = s_ready[k];
                hit_rdata_c = s_rdata[k];
            end
        end
        hit_ready_c = hit_ready_c && fwd_valid;
    end

    split_pipe_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_nx != BUSY),
        .ld    (1'b0),
        .ld_val('0),
        .en    (state == BUSY),
        .term  (TERM),
        .tc_c  (tc_c)
    );

    assign timeout_c = (TIMEOUT != 0) && tc_c;

`ifdef SPLIT_PIPE_REG_EN
    logic [VALID_BIT-1:0] req_q;
    logic                 valid_q;
    logic [RESP_W-1:0]    resp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            valid_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            resp_q <= resp_c;
            if ((state == IDLE) && (state_nx == BUSY)) begin
                req_q   <= m_req[VALID_BIT-1:0];
                valid_q <= 1'b1;
            end else if (state_nx != BUSY) begin
                valid_q <= 1'b0;
            end
        end
    end

    // The master still holds the old request while the registered response is shown.
    assign resp_hold_c = resp_q[READY_BIT];
    assign fwd_valid   = valid_q;
    assign fwd_sel     = sel_q;
    assign fwd_payload = req_q;
    assign m_resp      = resp_q;
`else
    assign resp_hold_c = 1'b0;
    assign fwd_valid   = ((state == IDLE) && m_valid && mapped_c) || (state == BUSY);
    assign fwd_sel     = (state == IDLE) ? sel_c : sel_q;
    assign fwd_payload = m_req[VALID_BIT-1:0];
    assign m_resp      = rst ? '0 : resp_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A same-cycle ready in IDLE completes the transfer without entering BUSY.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (m_valid && !resp_hold_c) begin
                    if (!mapped_c) begin
                        state_nx = ERR;
                    end else if (!hit_ready_c) begin
                        state_nx = BUSY;
                    end
                end
            end
            BUSY:    if (hit_ready_c || timeout_c) state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Slave ready wins over a coinciding timeout.
    always_comb begin
        resp_c    = '0;
        err_evt_c = 1'b0;
        if (hit_ready_c) begin
            resp_c[READY_BIT]             = 1'b1;
            resp_c[RDATA_LSB +: DATA_W]   = hit_rdata_c;
        end else if (((state == BUSY) && timeout_c) || (state == ERR)) begin
            resp_c[READY_BIT]             = 1'b1;
            resp_c[RDATA_LSB +: DATA_W]   = ERR_DATA;
            err_evt_c                     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            if ((state == IDLE) && m_valid && !resp_hold_c) begin
                sel_q <= sel_c;
            end
            if (err_evt_c) begin
                err <= 1'b1;
                if (!err) begin
                    err_addr <= m_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_split_pipe.sv
// tb_split_pipe: directed checks of routing, latency, error responses and reset for split_pipe.
module tb_split_pipe;
    import split_pipe_pkg::*;

    localparam int unsigned N      = 3;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned TO     = 8;
    localparam int unsigned REQ_W  = req_w(AW, DW);
    localparam int unsigned RESP_W = resp_w(DW);
    localparam int unsigned A_LSB  = addr_lsb(DW);
`ifdef SPLIT_PIPE_REG_EN
    localparam int FWD = 1;
    localparam int RET = 1;
`else
    localparam int FWD = 0;
    localparam int RET = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [REQ_W-1:0]    m_req = '0;
    logic [RESP_W-1:0]   m_resp;
    logic [N*REQ_W-1:0]  s_req;
    logic [N*RESP_W-1:0] s_resp;
    logic                err;
    logic [AW-1:0]       err_addr;

    int vectors = 0;
    int miscompares = 0;

    // Slave model: ready after 'delay' cycles of valid (-1 = never), plus stray ready injection.
    int            delay [N];
    logic [DW-1:0] rdata [N];
    logic          stray [N];
    int            wait_cnt [N];
    int            bursts [N];
    logic          prev_valid [N];
    logic [N-1:0]  s_val, s_rdy;

    always #5 clk = ~clk;

    split_pipe #(
        .N_SLAVES(N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .P_SLAVES(31),
        .TIMEOUT (TO),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_resp  (m_resp),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .err     (err),
        .err_addr(err_addr)
    );

    always_comb begin
        s_resp = '0;
        s_val  = '0;
        s_rdy  = '0;
        for (int k = 0; k < N; k++) begin
            s_val[k] = s_req[k*REQ_W + REQ_W - 1];
            s_rdy[k] = (s_val[k] && (delay[k] >= 0) && (wait_cnt[k] == delay[k])) || stray[k];
            s_resp[k*RESP_W +: RESP_W] = {rdata[k], s_rdy[k]};
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                wait_cnt[k]   <= 0;
                bursts[k]     <= 0;
                prev_valid[k] <= 1'b0;
            end else begin
                wait_cnt[k]   <= (s_val[k] && !s_rdy[k]) ? wait_cnt[k] + 1 : 0;
                if (s_val[k] && !prev_valid[k]) bursts[k] <= bursts[k] + 1;
                prev_valid[k] <= s_val[k];
            end
        end
    end

    // Called at the start of a cycle; returns at the start of the cycle after ready.
    task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic [3:0] ws,
                          output int lat, output logic [DW-1:0] rd, output logic [AW-1:0] bcast,
                          output bit got);
        m_req = {1'b1, addr, wd, ws};
        got = 1'b0;
        lat = -1;
        rd = '0;
        bcast = '0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (m_resp[READY_BIT]) begin
                got   = 1'b1;
                lat   = c;
                rd    = m_resp[RDATA_LSB +: DW];
                bcast = s_req[2*REQ_W + A_LSB +: AW];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++; if (m_resp !== '0) begin miscompares++; $display("FAIL reset_m_resp: got %h want 0", m_resp); end
        vectors++; if (s_val !== '0) begin miscompares++; $display("FAIL reset_valids: got %b want 000", s_val); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++; if (err_addr !== '0) begin miscompares++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
    endtask

    task automatic test_read();
        int b0 [N];
        int lat;
        logic [DW-1:0] rd;
        logic [AW-1:0] bc;
        bit got;
        for (int k = 0; k < N; k++) b0[k] = bursts[k];
        delay[1] = 3;
        rdata[1] = 32'h1234_5678;
        @(posedge clk); #1;
        do_txn(32'h4000_0010, 32'h0, 4'h0, lat, rd, bc, got);
        m_req = '0;
        @(negedge clk);
        vectors++; if (!got) begin miscompares++; $display("FAIL read_ready: no ready within bound"); end
        vectors++; if (lat !== 3 + FWD + RET) begin miscompares++; $display("FAIL read_latency: got %0d want %0d", lat, 3 + FWD + RET); end
        vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL read_rdata: got %h want 12345678", rd); end
        vectors++; if (bc !== 32'h4000_0010) begin miscompares++; $display("FAIL read_bcast_addr: got %h want 40000010", bc); end
        vectors++; if (m_resp[READY_BIT] !== 1'b0) begin miscompares++; $display("FAIL read_pulse: ready got %b want 0", m_resp[READY_BIT]); end
        vectors++; if (bursts[1] - b0[1] !== 1) begin miscompares++; $display("FAIL read_s1_bursts: got %0d want 1", bursts[1] - b0[1]); end
        vectors++; if ((bursts[0] - b0[0]) + (bursts[2] - b0[2]) !== 0)
            begin miscompares++; $display("FAIL read_other_bursts: got %0d want 0", (bursts[0] - b0[0]) + (bursts[2] - b0[2])); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL read_err: got %b want 0", err); end
    endtask

    task automatic test_unmapped();
        int b0 [N];
        int lat;
        logic [DW-1:0] rd;
        logic [AW-1:0] bc;
        bit got;
        for (int k = 0; k < N; k++) b0[k] = bursts[k];
        @(posedge clk); #1;
        do_txn(32'hC000_0000, 32'h0, 4'h0, lat, rd, bc, got);
        m_req = '0;
        @(negedge clk);
        vectors++; if (!got) begin miscompares++; $display("FAIL unmap_ready: no ready within bound"); end
        vectors++; if (lat !== 1 + RET) begin miscompares++; $display("FAIL unmap_latency: got %0d want %0d", lat, 1 + RET); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL unmap_rdata: got %h want deadbeef", rd); end
        vectors++; if ((bursts[0] - b0[0]) + (bursts[1] - b0[1]) + (bursts[2] - b0[2]) !== 0)
            begin miscompares++; $display("FAIL unmap_bursts: got %0d want 0", (bursts[0] - b0[0]) + (bursts[1] - b0[1]) + (bursts[2] - b0[2])); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL unmap_err: got %b want 1", err); end
        vectors++; if (err_addr !== 32'hC000_0000) begin miscompares++; $display("FAIL unmap_err_addr: got %h want c0000000", err_addr); end
    endtask

    task automatic test_timeout();
        int b0;
        int lat;
        logic [DW-1:0] rd;
        logic [AW-1:0] bc;
        bit got;
        b0 = bursts[0];
        delay[0] = -1;
        @(posedge clk); #1;
        do_txn(32'h0000_0100, 32'hA5A5_0F0F, 4'hF, lat, rd, bc, got);
        m_req = '0;
        @(negedge clk);
        vectors++; if (!got) begin miscompares++; $display("FAIL tmo_ready: no ready within bound"); end
        vectors++; if (lat !== TO + RET) begin miscompares++; $display("FAIL tmo_latency: got %0d want %0d", lat, TO + RET); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL tmo_rdata: got %h want deadbeef", rd); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL tmo_err: got %b want 1", err); end
        vectors++; if (err_addr !== 32'hC000_0000) begin miscompares++; $display("FAIL tmo_err_addr_kept: got %h want c0000000", err_addr); end
        vectors++; if (bursts[0] - b0 !== 1) begin miscompares++; $display("FAIL tmo_s0_bursts: got %0d want 1", bursts[0] - b0); end
        @(posedge clk); #1;
        stray[0] = 1'b1;
        @(negedge clk);
        vectors++; if (m_resp[READY_BIT] !== 1'b0) begin miscompares++; $display("FAIL tmo_stray_ready: got %b want 0", m_resp[READY_BIT]); end
        vectors++; if (s_val[0] !== 1'b0) begin miscompares++; $display("FAIL tmo_s0_valid: got %b want 0", s_val[0]); end
        @(posedge clk); #1;
        stray[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int b0 [N];
        int lat1, lat2;
        logic [DW-1:0] rd1, rd2;
        logic [AW-1:0] bc;
        bit got1, got2;
        for (int k = 0; k < N; k++) b0[k] = bursts[k];
        delay[2] = 1;
        rdata[2] = 32'h2222_0002;
        delay[0] = 0;
        rdata[0] = 32'h0000_0A0A;
        @(posedge clk); #1;
        do_txn(32'h8000_0004, 32'h0000_1111, 4'h3, lat1, rd1, bc, got1);
        do_txn(32'h0000_0008, 32'h0000_2222, 4'hC, lat2, rd2, bc, got2);
        m_req = '0;
        @(negedge clk);
        vectors++; if (!(got1 && got2)) begin miscompares++; $display("FAIL b2b_ready: got %b%b want 11", got1, got2); end
        vectors++; if (lat1 !== 1 + FWD + RET) begin miscompares++; $display("FAIL b2b_lat1: got %0d want %0d", lat1, 1 + FWD + RET); end
        vectors++; if (rd1 !== 32'h2222_0002) begin miscompares++; $display("FAIL b2b_rdata1: got %h want 22220002", rd1); end
        vectors++; if (lat2 !== FWD + RET) begin miscompares++; $display("FAIL b2b_lat2: got %0d want %0d", lat2, FWD + RET); end
        vectors++; if (rd2 !== 32'h0000_0A0A) begin miscompares++; $display("FAIL b2b_rdata2: got %h want 00000a0a", rd2); end
        vectors++; if (bursts[2] - b0[2] !== 1) begin miscompares++; $display("FAIL b2b_s2_bursts: got %0d want 1", bursts[2] - b0[2]); end
        vectors++; if (bursts[0] - b0[0] !== 1) begin miscompares++; $display("FAIL b2b_s0_bursts: got %0d want 1", bursts[0] - b0[0]); end
        vectors++; if (bursts[1] - b0[1] !== 0) begin miscompares++; $display("FAIL b2b_s1_bursts: got %0d want 0", bursts[1] - b0[1]); end
        vectors++; if (m_resp[READY_BIT] !== 1'b0) begin miscompares++; $display("FAIL b2b_pulse: ready got %b want 0", m_resp[READY_BIT]); end
    endtask

    task automatic test_abort();
        delay[1] = -1;
        @(posedge clk); #1;
        m_req = {1'b1, 32'h4000_0000, 32'h0, 4'h0};
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++; if (s_val !== 3'b010) begin miscompares++; $display("FAIL abort_pre_valid: got %b want 010", s_val); end
        @(posedge clk); #1;
        rst = 1'b1;
        m_req = '0;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (s_val !== '0) begin miscompares++; $display("FAIL abort_valid: got %b want 000", s_val); end
        vectors++; if (m_resp !== '0) begin miscompares++; $display("FAIL abort_m_resp: got %h want 0", m_resp); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL abort_err: got %b want 0", err); end
        vectors++; if (err_addr !== '0) begin miscompares++; $display("FAIL abort_err_addr: got %h want 0", err_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            delay[k] = 0;
            rdata[k] = '0;
            stray[k] = 1'b0;
        end
        test_reset();
        test_read();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1);
    end

endmodule
